// File: rtl/minmaxmid_seq_ctrl_if.sv
// rtl/minmaxmid_seq_ctrl_if.sv - sample stream, sorted-triple stream and status bus
// Producer-side (master) and controller-side (slave) views of the same bus.
interface minmaxmid_seq_ctrl_if #(
   parameter int W     = 7,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_min;
   logic [W-1:0]     out_mid;
   logic [W-1:0]     out_max;
   logic             busy;
   logic [CNT_W-1:0] tri_cnt;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_min, out_mid, out_max, busy, tri_cnt
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_min, out_mid, out_max, busy, tri_cnt
   );
endinterface

// File: rtl/minmaxmid_seq_ctrl.sv
// rtl/minmaxmid_seq_ctrl.sv - groups samples into triples and sorts them with one shared compare-and-swap
// Three bubble passes (r0/r1, r1/r2, r0/r1) fully order a triple, one pass per cycle.
module minmaxmid_seq_ctrl #(
   parameter int W     = 7,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   minmaxmid_seq_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {S_LOAD, S_CS1, S_CS2, S_CS3, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_cnt;
   logic [W-1:0]     r_s0, r_s1, r_s2;
   logic [W-1:0]     r_min, r_mid, r_max;
   logic [CNT_W-1:0] r_tri_cnt;

   logic             w_accept;
   logic             w_handoff;
   logic             w_swap;
   logic [W-1:0]     w_a, w_b, w_lo, w_hi;

   assign w_accept  = bus.in_valid && (r_state == S_LOAD);
   assign w_handoff = bus.out_ready && (r_state == S_DONE);

   // Operand mux for the single comparator: CS2 looks at r1/r2, CS1 and CS3 at r0/r1.
   always_comb begin
      w_a = r_s0;
      w_b = r_s1;
      if (r_state == S_CS2) begin
         w_a = r_s1;
         w_b = r_s2;
      end
      w_swap = (r_state inside {S_CS1, S_CS2, S_CS3}) && (w_a > w_b);
      w_lo   = w_swap ? w_b : w_a;
      w_hi   = w_swap ? w_a : w_b;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LOAD:  if (w_accept && (r_cnt == 2'd2)) w_next = S_CS1;
         S_CS1:   w_next = S_CS2;
         S_CS2:   w_next = S_CS3;
         S_CS3:   w_next = S_DONE;
         S_DONE:  if (w_handoff) w_next = S_LOAD;
         default: w_next = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_LOAD;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= 2'd0;
         r_s0      <= '0;
         r_s1      <= '0;
         r_s2      <= '0;
         r_min     <= '0;
         r_mid     <= '0;
         r_max     <= '0;
         r_tri_cnt <= '0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (w_accept) begin
                  case (r_cnt)
                     2'd0:    r_s0 <= bus.in_data;
                     2'd1:    r_s1 <= bus.in_data;
                     default: r_s2 <= bus.in_data;
                  endcase
                  r_cnt <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
               end
            end
            S_CS1: begin
               r_s0 <= w_lo;
               r_s1 <= w_hi;
            end
            S_CS2: begin
               r_s1 <= w_lo;
               r_s2 <= w_hi;
            end
            S_CS3: begin
               // r2 already holds the maximum after the CS2 pass.
               r_s0  <= w_lo;
               r_s1  <= w_hi;
               r_min <= w_lo;
               r_mid <= w_hi;
               r_max <= r_s2;
            end
            S_DONE: begin
               if (w_handoff) r_tri_cnt <= r_tri_cnt + 1'b1;
            end
            default: r_cnt <= 2'd0;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_LOAD);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.out_min   = r_min;
   assign bus.out_mid   = r_mid;
   assign bus.out_max   = r_max;
   assign bus.busy      = !((r_state == S_LOAD) && (r_cnt == 2'd0));
   assign bus.tri_cnt   = r_tri_cnt;
endmodule

// File: tb/tb_minmaxmid_seq_ctrl.sv
// tb/tb_minmaxmid_seq_ctrl.sv - scoreboard bench for the min/mid/max sequencing controller
// Stimulus pushes expected {min,mid,max}; a negedge monitor pops on every handoff.
module tb_minmaxmid_seq_ctrl;
   localparam int W     = 7;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   minmaxmid_seq_ctrl_if #(.W(W), .CNT_W(CNT_W)) bus ();
   minmaxmid_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int               n_tests = 0;
   int               n_fail  = 0;
   logic [3*W-1:0]   exp_q[$];
   logic [CNT_W-1:0] exp_cnt = '0;
   logic             swap_watch = 1'b0;
   logic             swap_seen  = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         chk("pending_expected", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            logic [3*W-1:0] e;
            e = exp_q.pop_front();
            chk("out_min", bus.out_min, e[3*W-1:2*W]);
            chk("out_mid", bus.out_mid, e[2*W-1:W]);
            chk("out_max", bus.out_max, e[W-1:0]);
            chk("tri_cnt_at_handoff", bus.tri_cnt, exp_cnt);
            exp_cnt = exp_cnt + 1'b1;
         end
      end
      if (swap_watch && dut.w_swap) swap_seen = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout, required completion");
      $fatal(1, "global timeout");
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      exp_q.delete();
      exp_cnt = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_out_min"},   bus.out_min, 0);
      chk({tag, "_out_mid"},   bus.out_mid, 0);
      chk({tag, "_out_max"},   bus.out_max, 0);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_tri_cnt"},   bus.tri_cnt, 0);
      chk({tag, "_busy"},      bus.busy, 0);
      chk({tag, "_in_ready"},  bus.in_ready, 1);
   endtask

   // Returns just after the accepting edge.
   task automatic send(input logic [W-1:0] v, input int gap);
      int t;
      t = 0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      while (!bus.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         chk("in_ready_timeout", t, 0);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic send_triple(input logic [W-1:0] a, b, c, emin, emid, emax, input int gapmax);
      exp_q.push_back({emin, emid, emax});
      send(a, $urandom_range(0, gapmax));
      send(b, $urandom_range(0, gapmax));
      send(c, $urandom_range(0, gapmax));
      chk("in_ready_sorting", bus.in_ready, 0);
      chk("busy_sorting", bus.busy, 1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain_left", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3*W-1:0] ref_sort(input logic [W-1:0] a, b, c);
      logic [W-1:0] mn, md, mx;
      mn = (a <= b && a <= c) ? a : ((b <= c) ? b : c);
      mx = (a >= b && a >= c) ? a : ((b >= c) ? b : c);
      if ((a >= b && a <= c) || (a <= b && a >= c))      md = a;
      else if ((b >= a && b <= c) || (b <= a && b >= c)) md = b;
      else                                               md = c;
      return {mn, md, mx};
   endfunction

   initial begin
      logic [W-1:0] a, b, c;
      logic [3*W-1:0] s;
      int t;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      do_reset();
      check_cleared("reset");

      // Basic triple with latency check
      exp_q.push_back({7'd3, 7'd5, 7'd9});
      send(7'd9, 0);
      send(7'd3, 0);
      send(7'd5, 0);
      chk("lat_edge0_valid", bus.out_valid, 0);
      @(posedge clk); #1 chk("lat_edge1_valid", bus.out_valid, 0);
      @(posedge clk); #1 chk("lat_edge2_valid", bus.out_valid, 0);
      @(posedge clk); #1 chk("lat_edge3_valid", bus.out_valid, 1);
      chk("lat_edge3_in_ready", bus.in_ready, 0);
      drain();
      chk("t1_tri_cnt", bus.tri_cnt, 1);
      chk("t1_busy_idle", bus.busy, 0);

      // Extremes and duplicates
      send_triple(7'd127, 7'd127, 7'd0, 7'd0, 7'd127, 7'd127, 0);
      drain();
      swap_seen  = 1'b0;
      swap_watch = 1'b1;
      send_triple(7'd4, 7'd4, 7'd4, 7'd4, 7'd4, 7'd4, 0);
      drain();
      swap_watch = 1'b0;
      chk("equal_no_swap", swap_seen, 0);

      // All orderings of {1,2,3} with input gaps
      do_reset();
      send_triple(7'd1, 7'd2, 7'd3, 7'd1, 7'd2, 7'd3, 3);
      send_triple(7'd1, 7'd3, 7'd2, 7'd1, 7'd2, 7'd3, 3);
      send_triple(7'd2, 7'd1, 7'd3, 7'd1, 7'd2, 7'd3, 3);
      send_triple(7'd2, 7'd3, 7'd1, 7'd1, 7'd2, 7'd3, 3);
      send_triple(7'd3, 7'd1, 7'd2, 7'd1, 7'd2, 7'd3, 3);
      send_triple(7'd3, 7'd2, 7'd1, 7'd1, 7'd2, 7'd3, 3);
      drain();
      chk("perm_tri_cnt", bus.tri_cnt, 6);

      // Back-pressure hold in DONE
      bus.out_ready = 1'b0;
      send_triple(7'd30, 7'd10, 7'd20, 7'd10, 7'd20, 7'd30, 0);
      t = 0;
      while (!bus.out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("hold_valid_rise", bus.out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = 7'd99;
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_min", bus.out_min, 10);
         chk("hold_mid", bus.out_mid, 20);
         chk("hold_max", bus.out_max, 30);
         chk("hold_in_ready", bus.in_ready, 0);
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drain();
      chk("hold_tri_cnt", bus.tri_cnt, 7);
      chk("hold_not_consumed", bus.busy, 0);
      chk("hold_min_retained", bus.out_min, 10);

      // Reset during partial load and during sorting
      do_reset();
      send(7'd1, 0);
      send(7'd2, 0);
      chk("partial_busy", bus.busy, 1);
      do_reset();
      check_cleared("rst_load");
      send(7'd5, 0);
      send(7'd6, 0);
      send(7'd8, 0);
      @(posedge clk);
      #1 chk("cs2_busy", bus.busy, 1);
      do_reset();
      check_cleared("rst_cs2");
      send_triple(7'd7, 7'd1, 7'd4, 7'd1, 7'd4, 7'd7, 0);
      drain();
      chk("after_rst_tri_cnt", bus.tri_cnt, 1);

      // Counter wrap with a random stream
      do_reset();
      for (int i = 0; i < 257; i++) begin
         a = W'($urandom_range(0, 127));
         b = W'($urandom_range(0, 127));
         c = W'($urandom_range(0, 127));
         s = ref_sort(a, b, c);
         send_triple(a, b, c, s[3*W-1:2*W], s[2*W-1:W], s[W-1:0], 1);
      end
      drain();
      chk("wrap_tri_cnt", bus.tri_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
